dmem_responder: RTL and testbench

Data-memory responder for the single-cycle RISC-V core. It answers the core's `MemRead`/`MemWrite` requests over the 9-bit byte address space with configurable wait states and RV32I byte/half/word sizing. It performs sign or zero extension on loads and flags misaligned accesses. It sits between the datapath's memory port and a 128 x 32-bit storage array that it owns.

---
 rtl/dmem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: 128x32 storage with RV32I byte/half/word loads and stores.
// Latency: capture + LATENCY wait cycles, then one ACCESS cycle with done; inputs are held by the core until done.
module dmem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [2:0]        Funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int         DEPTH = 1 << (ADDR_W - 2);
  localparam logic [2:0] LAT   = LATENCY[2:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          f3_q, f3_d;
  logic [DATA_W-1:0]   wdat_q, wdat_d;
  logic                rd_q, rd_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [DATA_W-1:0]   mem [DEPTH];

  // With zero latency the access happens on the capture edge, so operands
  // come straight from the inputs; otherwise from the captured copy.
  logic                from_idle;
  logic [ADDR_W-1:0]   op_addr;
  logic [2:0]          op_f3;
  logic [DATA_W-1:0]   op_wdat;
  logic                op_rd;
  logic                op_wr;
  logic [1:0]          lane;
  logic [ADDR_W-3:0]   idx;

  assign from_idle = (state_q == S_IDLE);
  assign op_addr   = from_idle ? addr     : addr_q;
  assign op_f3     = from_idle ? Funct3   : f3_q;
  assign op_wdat   = from_idle ? wr_data  : wdat_q;
  assign op_rd     = from_idle ? MemRead  : rd_q;
  assign op_wr     = from_idle ? MemWrite : wr_q;
  assign lane      = op_addr[1:0];
  assign idx       = op_addr[ADDR_W-1:2];

  logic illegal;

  always_comb begin
    illegal = 1'b0;
    if (op_rd && op_wr)
      illegal = 1'b1;
    if ((op_f3[1:0] == 2'b01) && lane[0])
      illegal = 1'b1;
    if ((op_f3[1:0] == 2'b10) && (lane != 2'b00))
      illegal = 1'b1;
    if (op_rd && ((op_f3 == 3'b011) || (op_f3[2:1] == 2'b11)))
      illegal = 1'b1;
  end

  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] word_sh;
  logic [DATA_W-1:0] load_val;

  always_comb begin
    word    = mem[idx];
    word_sh = word >> {lane, 3'b000};
    case (op_f3)
      3'b000:  load_val = {{(DATA_W-8){word_sh[7]}}, word_sh[7:0]};
      3'b001:  load_val = {{(DATA_W-16){word_sh[15]}}, word_sh[15:0]};
      3'b100:  load_val = {{(DATA_W-8){1'b0}}, word_sh[7:0]};
      3'b101:  load_val = {{(DATA_W-16){1'b0}}, word_sh[15:0]};
      default: load_val = word;
    endcase
  end

  // Byte enables and lane-aligned store data; a store ignores Funct3[2].
  logic [3:0]        be;
  logic [DATA_W-1:0] wshift;

  always_comb begin
    case (op_f3[1:0])
      2'b00:   be = 4'b0001 << lane;
      2'b01:   be = 4'b0011 << lane;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    wshift = op_wdat << {lane, 3'b000};
  end

  logic access;
  logic do_write;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    f3_d      = f3_q;
    wdat_d    = wdat_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    rd_data_d = rd_data_q;
    access    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (MemRead || MemWrite) begin
          addr_d = addr;
          f3_d   = Funct3;
          wdat_d = wr_data;
          rd_d   = MemRead;
          wr_d   = MemWrite;
          cnt_d  = LAT;
          if (LAT == 3'd0) begin
            state_d = S_ACCESS;
            access  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = S_ACCESS;
          access  = 1'b1;
        end
      end
      S_ACCESS: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (access && op_rd && !illegal)
      rd_data_d = load_val;

    do_write = access && op_wr && !illegal;
    busy_d   = (state_d != S_IDLE);
    done_d   = access;
    err_d    = access && illegal;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 3'd0;
      addr_q    <= '0;
      f3_q      <= 3'd0;
      wdat_q    <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      rd_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      f3_q      <= f3_d;
      wdat_q    <= wdat_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Storage is never cleared; reset only blocks a commit on the same edge.
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem[idx][8*i +: 8] <= wshift[8*i +: 8];
      end
    end
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (LATENCY 2 and 0) against a byte-array reference model.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mr, mw;
  logic [8:0]  ad   [2];
  logic [2:0]  fn   [2];
  logic [31:0] wdv  [2];
  logic [31:0] rdo  [2];
  logic [1:0]  busy_o, done_o, err_o;

  int errors = 0;
  int checks = 0;

  logic [7:0]  bm  [2][512];
  logic [31:0] mrd [2];
  int          lat [2];

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .MemRead(mr[0]), .MemWrite(mw[0]), .addr(ad[0]),
    .Funct3(fn[0]), .wr_data(wdv[0]), .rd_data(rdo[0]), .busy(busy_o[0]),
    .done(done_o[0]), .err(err_o[0]));

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .LATENCY(0)) u_l0 (
    .clk(clk), .reset(reset), .MemRead(mr[1]), .MemWrite(mw[1]), .addr(ad[1]),
    .Funct3(fn[1]), .wr_data(wdv[1]), .rd_data(rdo[1]), .busy(busy_o[1]),
    .done(done_o[1]), .err(err_o[1]));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  function automatic int msize(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit millegal(input bit r, input bit w, input logic [8:0] a, input logic [2:0] f3);
    int sz;
    sz = msize(f3);
    if (r && w) return 1'b1;
    if (r && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    if (sz == 2 && (a % 2) != 0) return 1'b1;
    if (sz == 4 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mload(input int s, input logic [8:0] a, input logic [2:0] f3);
    logic [31:0] v;
    int sz;
    sz = msize(f3);
    v  = 32'd0;
    for (int i = 0; i < sz; i++)
      v = v | (32'(bm[s][int'(a) + i]) << (8 * i));
    if (!f3[2] && sz == 1 && v[7])  v = v | 32'hFFFFFF00;
    if (!f3[2] && sz == 2 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic drive(input int s, input bit r, input bit w, input logic [8:0] a,
                       input logic [2:0] f3, input logic [31:0] wd);
    mr[s]  = r;
    mw[s]  = w;
    ad[s]  = a;
    fn[s]  = f3;
    wdv[s] = wd;
  endtask

  // One request, inputs held until done; checks latency, busy, done/err pulse and load data.
  task automatic do_req(input int s, input bit r, input bit w, input logic [8:0] a,
                        input logic [2:0] f3, input logic [31:0] wd, input string nm,
                        output logic [31:0] grd, output logic gerr);
    int n;
    bit ill;
    logic [31:0] exp;
    ill = millegal(r, w, a, f3);
    exp = mrd[s];
    if (!ill && r) exp = mload(s, a, f3);
    drive(s, r, w, a, f3, wd);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done_o[s]) chk({nm, " busy_wait"}, 32'(busy_o[s]), 32'd1);
    end while (!done_o[s] && n < 20);
    chk({nm, " latency"}, n, lat[s] + 1);
    chk({nm, " busy_done"}, 32'(busy_o[s]), 32'd1);
    chk({nm, " err"}, 32'(err_o[s]), 32'(ill));
    chk({nm, " rd_data"}, rdo[s], exp);
    grd  = rdo[s];
    gerr = err_o[s];
    drive(s, 1'b0, 1'b0, 9'd0, 3'd0, 32'd0);
    @(negedge clk);
    chk({nm, " done_fall"}, 32'(done_o[s]), 32'd0);
    chk({nm, " err_fall"}, 32'(err_o[s]), 32'd0);
    chk({nm, " busy_fall"}, 32'(busy_o[s]), 32'd0);
    if (!ill && w) begin
      for (int i = 0; i < msize(f3); i++)
        bm[s][int'(a) + i] = 8'(wd >> (8 * i));
    end
    mrd[s] = exp;
  endtask

  // Request held high: retires every lat+2 cycles, busy low only in the IDLE cycle.
  task automatic held(input int s, input logic [8:0] a, input logic [31:0] expv);
    int per;
    bit ed;
    per = lat[s] + 2;
    drive(s, 1'b1, 1'b0, a, 3'b010, 32'd0);
    for (int n = 1; n <= 3 * per - 1; n++) begin
      @(negedge clk);
      ed = ((n % per) == lat[s] + 1);
      chk($sformatf("held%0d done n=%0d", s, n), 32'(done_o[s]), 32'(ed));
      chk($sformatf("held%0d busy n=%0d", s, n), 32'(busy_o[s]), 32'((n % per) != 0));
      if (ed) chk($sformatf("held%0d rd n=%0d", s, n), rdo[s], expv);
    end
    drive(s, 1'b0, 1'b0, 9'd0, 3'd0, 32'd0);
    @(negedge clk);
    mrd[s] = expv;
  endtask

  typedef struct {
    bit          r;
    bit          w;
    logic [8:0]  a;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [19];

  initial begin
    logic [31:0] grd;
    logic        gerr;
    lat[0] = 2;
    lat[1] = 0;

    tbl[0]  = '{1'b0, 1'b1, 9'h010, 3'b010, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 9'h010, 3'b010, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 9'h010, 3'b010, 32'h00000000, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 9'h013, 3'b000, 32'h00000080, 32'hDEADBEEF, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 9'h013, 3'b000, 32'h0,        32'hFFFFFF80, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 9'h013, 3'b100, 32'h0,        32'h00000080, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 9'h010, 3'b010, 32'h0,        32'h80000000, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 9'h022, 3'b001, 32'h00001234, 32'h80000000, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 9'h022, 3'b001, 32'h0,        32'h00001234, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 9'h022, 3'b001, 32'h0000F00D, 32'h00001234, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 9'h022, 3'b101, 32'h0,        32'h0000F00D, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 9'h022, 3'b001, 32'h0,        32'hFFFFF00D, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 9'h011, 3'b010, 32'h0,        32'hFFFFF00D, 1'b1};
    tbl[13] = '{1'b0, 1'b1, 9'h023, 3'b001, 32'h0000AAAA, 32'hFFFFF00D, 1'b1};
    tbl[14] = '{1'b1, 1'b0, 9'h023, 3'b100, 32'h0,        32'h000000F0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 9'h010, 3'b011, 32'h0,        32'h000000F0, 1'b1};
    tbl[16] = '{1'b1, 1'b1, 9'h010, 3'b010, 32'h12345678, 32'h000000F0, 1'b1};
    tbl[17] = '{1'b1, 1'b0, 9'h010, 3'b010, 32'h0,        32'h80000000, 1'b0};
    tbl[18] = '{1'b1, 1'b0, 9'h012, 3'b000, 32'h0,        32'h00000000, 1'b0};

    reset = 1'b1;
    for (int s = 0; s < 2; s++) drive(s, 1'b0, 1'b0, 9'd0, 3'd0, 32'd0);
    mrd[0] = 32'd0;
    mrd[1] = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk($sformatf("reset rd_data%0d", s), rdo[s], 32'd0);
      chk($sformatf("reset busy%0d", s), 32'(busy_o[s]), 32'd0);
      chk($sformatf("reset done%0d", s), 32'(done_o[s]), 32'd0);
      chk($sformatf("reset err%0d", s), 32'(err_o[s]), 32'd0);
    end

    for (int i = 0; i < 19; i++) begin
      do_req(0, tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].f3, tbl[i].wd, $sformatf("tbl%0d", i), grd, gerr);
      chk($sformatf("tbl%0d const_rd", i), grd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d const_err", i), 32'(gerr), 32'(tbl[i].exp_err));
    end

    do_req(1, 1'b0, 1'b1, 9'h100, 3'b010, 32'hCAFEF00D, "l0 sw", grd, gerr);
    do_req(1, 1'b1, 1'b0, 9'h101, 3'b000, 32'h0, "l0 lb", grd, gerr);
    chk("l0 lb const", grd, 32'hFFFFFFF0);
    do_req(1, 1'b1, 1'b0, 9'h102, 3'b001, 32'h0, "l0 lh", grd, gerr);
    chk("l0 lh const", grd, 32'hFFFFCAFE);
    held(1, 9'h100, 32'hCAFEF00D);
    held(0, 9'h010, 32'h80000000);

    do_req(0, 1'b0, 1'b1, 9'h040, 3'b010, 32'h11111111, "rst sw1", grd, gerr);
    drive(0, 1'b0, 1'b1, 9'h040, 3'b010, 32'h22222222);
    @(negedge clk);
    chk("rst busy_before", 32'(busy_o[0]), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst rd_data", rdo[0], 32'd0);
    chk("rst busy", 32'(busy_o[0]), 32'd0);
    chk("rst done", 32'(done_o[0]), 32'd0);
    chk("rst err", 32'(err_o[0]), 32'd0);
    drive(0, 1'b0, 1'b0, 9'd0, 3'd0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mrd[0] = 32'd0;
    mrd[1] = 32'd0;
    @(negedge clk);
    do_req(0, 1'b1, 1'b0, 9'h040, 3'b010, 32'h0, "rst lw", grd, gerr);
    chk("rst lw const", grd, 32'h11111111);

    for (int s = 0; s < 2; s++) begin
      for (int wi = 0; wi < 128; wi++)
        do_req(s, 1'b0, 1'b1, 9'(wi * 4), 3'b010, $urandom, "init", grd, gerr);
      for (int t = 0; t < 150; t++) begin
        int k;
        bit r, w;
        logic [8:0] a;
        logic [2:0] f3;
        k  = $urandom_range(0, 19);
        r  = (k < 9) || (k == 19);
        w  = (k >= 9);
        a  = 9'($urandom_range(0, 511));
        f3 = 3'($urandom_range(0, 7));
        if (w && !r && f3[1:0] == 2'b11) f3 = {f3[2], 2'b10};
        if ($urandom_range(0, 3) != 0) begin
          if (f3[1:0] == 2'b01) a[0] = 1'b0;
          else if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
        end
        do_req(s, r, w, a, f3, $urandom, $sformatf("rnd%0d_%0d", s, t), grd, gerr);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
